psum_col_acc: RTL
=================

Name: psum_col_acc

Overview:
- Drain stage directly downstream of one MAC column. It consumes the 40-bit partial sums leaving the bottom PE on p_o.
- Accumulates sums across K-tiles in a per-row buffer. On the last tile it requantizes each sum to 16 bits and queues it in an output FIFO with a valid/ready handshake.
- The systolic column cannot stall, so the input side has no backpressure. Overflow is flagged, never stalled.

Parameters:
- ACC_W, 40, partial-sum/accumulator width; matches the MAC p_o width.
- OUT_W, 16, output width; matches the activation width fed back to the array.
- ROWS, 4, number of output positions per tile (buffer entries).
- FIFO_DEPTH, 8, output FIFO entries (power of 2).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begins a job (sampled in IDLE only)
- num_tiles  in  8  K-tile count; sampled at start
- shift  in  5  requant right-shift amount; sampled at start
- p_i  in  ACC_W  signed partial sum from the column's last PE
- p_valid  in  1  p_i valid this cycle
- out_data  out  OUT_W  signed requantized result (FIFO head)
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts out_data
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse when job completes
- ovf_err  out  1  sticky: result dropped because FIFO full

Behaviour:
- Reset values: out_data=0, out_valid=0, busy=0, done=0, ovf_err=0. Reset also clears FIFO pointers, row index, tile counter and the buffer, and returns the FSM to IDLE. Reset mid-job aborts the job with no done pulse.
- FSM states: IDLE, RUN.
  - IDLE -> RUN on start. Latch num_tiles (0 is treated as 1) and shift; clear row_idx and tile_cnt.
  - RUN -> IDLE after the last p_valid of the last tile.
  - done pulses in the cycle after that transition.
- start in RUN is ignored. p_valid in IDLE is ignored.
- Per accepted p_valid in RUN:
  - sum = (tile_cnt==0 ? 0 : buf[row_idx]) + p_i, signed, wrapping modulo 2^ACC_W with no saturation.
  - If tile_cnt < num_tiles-1: buf[row_idx] <= sum.
  - If tile_cnt == num_tiles-1: sum goes to the requant stage and buf[row_idx] <= 0.
  - row_idx increments and wraps ROWS-1 -> 0. On wrap, tile_cnt increments.
- Requant stage is one register stage:
  - r = (sum + (shift>0 ? 1<<(shift-1) : 0)) >>> shift (arithmetic).
  - Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Pushes into the FIFO in the next cycle.
- Latency: a last-tile p_valid in cycle t gives out_valid=1 in cycle t+2 when the FIFO was empty.
- FIFO behaviour:
  - Registered head; out_data is stable while out_valid && !out_ready.
  - Pop occurs when out_valid && out_ready.
  - A push is accepted if the FIFO is not full, or if full with a pop in the same cycle (simultaneous push and pop keeps the count unchanged).
  - A push while full with no pop drops the value and sets ovf_err (sticky until rst). FIFO contents are unaffected.
  - Pointers wrap modulo FIFO_DEPTH.
- Back-to-back jobs:
  - start is accepted in the cycle after done.
  - FIFO contents carry over between jobs and are not flushed by start.

Test Plan:
- ROWS=4, num_tiles=1, shift=0, p_i=1,2,3,4 on consecutive cycles, out_ready=1 -> out_data 1,2,3,4 in order; first out_valid 2 cycles after p_i=1; done pulse once; busy low afterwards.
- num_tiles=3, shift=0, three tiles each p_i=10,20,30,40 -> outputs exactly 30,60,90,120; no output during tiles 0-1; buffer reads 0 at the next job start.
- Requant and saturation, num_tiles=1:
  - shift=2, p_i=6 -> 2; p_i=-6 -> -1.
  - shift=0, p_i=100000 -> 32767; p_i=-100000 -> -32768.
  - shift=0, p_i=-1 -> -1.
- Overflow: out_ready=0, three num_tiles=1 jobs (12 results) -> out_valid=1 with 8 entries held; ovf_err=1 after the 9th push. Then out_ready=1 -> first 8 values drain intact in order; ovf_err stays 1.
- Simultaneous push/pop at full: FIFO full, out_ready=1 while a new result arrives -> no drop, ovf_err stays 0, count stays 8.
- Reset mid-job: rst after 2 of 4 p_valid in tile 0 of num_tiles=2 -> next cycle busy=0, out_valid=0, ovf_err=0, no done. A fresh num_tiles=1 job with 5,6,7,8 outputs 5,6,7,8, so no stale buffer contents.

Source files
------------

// File: rtl/psum_col_acc.sv
// rtl/psum_col_acc.sv - MAC column drain: K-tile accumulation, requantization, output FIFO
// Input side never stalls; results that find the FIFO full are dropped and flagged.
module psum_col_acc #(
    parameter int ACC_W      = 40,
    parameter int OUT_W      = 16,
    parameter int ROWS       = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [7:0]              num_tiles,
    input  logic [4:0]              shift,
    input  logic signed [ACC_W-1:0] p_i,
    input  logic                    p_valid,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    ovf_err
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state;
    logic [7:0]              tiles_m1;
    logic [7:0]              tile_cnt;
    logic [4:0]              shift_q;
    logic [RW-1:0]           row_idx;
    logic signed [ACC_W-1:0] acc_buf [ROWS];

    logic                    q_valid;
    logic signed [OUT_W-1:0] q_data;

    logic signed [OUT_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]             wr_ptr;
    logic [AW:0]             rd_ptr;

    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W:0]   rnd_sum;
    logic signed [ACC_W:0]   shifted;
    logic signed [OUT_W-1:0] rq;
    logic                    last_row;
    logic                    last_tile;
    logic                    full;
    logic                    pop;
    logic                    push_ok;

    always_comb begin
        sum = ((tile_cnt == 8'd0) ? '0 : acc_buf[row_idx]) + p_i;
        // One extra bit so the rounding add cannot wrap before saturation.
        rnd_sum = {sum[ACC_W-1], sum};
        if (shift_q != 5'd0) begin
            rnd_sum = rnd_sum + ((ACC_W+1)'(1) << (shift_q - 5'd1));
        end
        shifted = rnd_sum >>> shift_q;
        if (shifted > SAT_MAX) begin
            rq = SAT_MAX[OUT_W-1:0];
        end else if (shifted < SAT_MIN) begin
            rq = SAT_MIN[OUT_W-1:0];
        end else begin
            rq = shifted[OUT_W-1:0];
        end
    end

    assign last_row  = (row_idx == RW'(ROWS-1));
    assign last_tile = (tile_cnt == tiles_m1);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign out_valid = (wr_ptr != rd_ptr);
    assign out_data  = mem[rd_ptr[AW-1:0]];
    assign pop       = out_valid && out_ready;
    assign push_ok   = q_valid && (!full || pop);
    assign busy      = (state == RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tiles_m1 <= '0;
            tile_cnt <= '0;
            shift_q  <= '0;
            row_idx  <= '0;
            q_valid  <= 1'b0;
            q_data   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            done     <= 1'b0;
            ovf_err  <= 1'b0;
            for (int i = 0; i < ROWS; i++) begin
                acc_buf[i] <= '0;
            end
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            done    <= 1'b0;
            q_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= RUN;
                        tiles_m1 <= (num_tiles == 8'd0) ? 8'd0 : num_tiles - 8'd1;
                        shift_q  <= shift;
                        row_idx  <= '0;
                        tile_cnt <= '0;
                    end
                end
                RUN: begin
                    if (p_valid) begin
                        if (last_tile) begin
                            acc_buf[row_idx] <= '0;
                            q_valid          <= 1'b1;
                            q_data           <= rq;
                        end else begin
                            acc_buf[row_idx] <= sum;
                        end
                        if (last_row) begin
                            row_idx <= '0;
                            if (last_tile) begin
                                state <= IDLE;
                                done  <= 1'b1;
                            end else begin
                                tile_cnt <= tile_cnt + 8'd1;
                            end
                        end else begin
                            row_idx <= row_idx + RW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
            if (push_ok) begin
                mem[wr_ptr[AW-1:0]] <= q_data;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (q_valid && full && !pop) begin
                ovf_err <= 1'b1;
            end
        end
    end
endmodule
